// File: rtl/bram_tdp_be.sv
// bram_tdp_be: true-dual-port block RAM with per-lane byte enables.
//
// Both ports share one clock. Each port has a read enable, a write enable,
// separate read and write addresses, and byte-lane write enables. The
// same-port read-during-write behaviour is selectable. An optional output
// register can be added. After reset, a sequencer zero-fills the array
// before either port is allowed to access it.
//
// Parameters
//   AWIDTH          address width, depth = 2**AWIDTH words
//   DWIDTH          data width per port
//   BWIDTH          bits per byte-enable lane; the top lane may be narrower
//   RDW_MODE        0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
//   OUT_REG         1 adds a second output stage on both ports
//   CLEAR_ON_RESET  1 zero-fills the array after reset is released
//
// Ports (x = a, b)
//   clk        single rising-edge clock for all state
//   rst        asynchronous active-high reset
//   rce_x      read enable;  ra_x read address
//   wce_x      write enable; wa_x write address, wd_x data, wbe_x lane enables
//   rq_x       read data
//   rvalid_x   rq_x carries data for a read accepted 1+OUT_REG cycles ago
//   init_done  array ready; port requests are ignored while low
module bram_tdp_be #(
   parameter int AWIDTH         = 10,
   parameter int DWIDTH         = 36,
   parameter int BWIDTH         = 9,
   parameter int RDW_MODE       = 0,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int NBE           = (DWIDTH + BWIDTH - 1) / BWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rce_a,
   input  logic [AWIDTH-1:0] ra_a,
   input  logic              wce_a,
   input  logic [AWIDTH-1:0] wa_a,
   input  logic [DWIDTH-1:0] wd_a,
   input  logic [NBE-1:0]    wbe_a,
   output logic [DWIDTH-1:0] rq_a,
   output logic              rvalid_a,
   input  logic              rce_b,
   input  logic [AWIDTH-1:0] ra_b,
   input  logic              wce_b,
   input  logic [AWIDTH-1:0] wa_b,
   input  logic [DWIDTH-1:0] wd_b,
   input  logic [NBE-1:0]    wbe_b,
   output logic [DWIDTH-1:0] rq_b,
   output logic              rvalid_b,
   output logic              init_done
);

   localparam int DEPTH = 1 << AWIDTH;
   localparam logic [AWIDTH:0] CLR_LAST = (AWIDTH + 1)'(DEPTH - 1);
   localparam bit WRITE_FIRST = (RDW_MODE == 1);
   localparam bit NO_CHANGE   = (RDW_MODE == 2);

   typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_READY} state_t;

   state_t            state, state_next;
   logic [AWIDTH:0]   clr_cnt, clr_cnt_next;
   logic              clear_we;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AWIDTH-1:0] addr_a, addr_b;
   logic              we_a, we_b, re_a, re_b;
   logic [DWIDTH-1:0] mask_a, mask_b;
   logic [DWIDTH-1:0] old_a, old_b, new_a, new_b, wr_a;
   logic [DWIDTH-1:0] rd_a, rd_b;
   logic              rv1_a, rv1_b;

   // Expand the lane enables into per-bit masks so a narrower top lane
   // simply ends at DWIDTH.
   for (genvar g = 0; g < DWIDTH; g++) begin : g_mask
      assign mask_a[g] = wbe_a[g / BWIDTH];
      assign mask_b[g] = wbe_b[g / BWIDTH];
   end

   // Clear sequencer state register. The counter is one bit wider than the
   // address so the sweep never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_RST;
         clr_cnt <= '0;
      end else begin
         state   <= state_next;
         clr_cnt <= clr_cnt_next;
      end
   end

   // Clear sequencer next state: leave RST on the first clock after reset,
   // then sweep every address once before declaring the array ready.
   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt;
      case (state)
         ST_RST: begin
            clr_cnt_next = '0;
            state_next   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         end
         ST_CLEAR: begin
            clr_cnt_next = clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) state_next = ST_READY;
         end
         ST_READY: state_next = ST_READY;
         default:  state_next = ST_RST;
      endcase
   end

   assign init_done = (state == ST_READY);
   assign clear_we  = (state == ST_CLEAR);

   // Port request decode. With both enables set the write lands on the
   // read address; in NO_CHANGE mode such a cycle is not a read at all.
   assign addr_a = rce_a ? ra_a : wa_a;
   assign addr_b = rce_b ? ra_b : wa_b;
   assign we_a   = wce_a & init_done & (|wbe_a);
   assign we_b   = wce_b & init_done & (|wbe_b);
   assign re_a   = rce_a & init_done & ~(NO_CHANGE & wce_a);
   assign re_b   = rce_b & init_done & ~(NO_CHANGE & wce_b);

   // Merged write words. On a same-address collision port A's word also
   // carries the lanes only B enabled, so the later A write keeps them.
   always_comb begin
      old_a = mem[addr_a];
      old_b = mem[addr_b];
      new_a = (old_a & ~mask_a) | (wd_a & mask_a);
      new_b = (old_b & ~mask_b) | (wd_b & mask_b);
      wr_a  = new_a;
      if (we_b && (addr_b == addr_a))
         wr_a = (new_a & ~(mask_b & ~mask_a)) | (wd_b & mask_b & ~mask_a);
   end

   // Array write port. Port A is written last so it wins any collision.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem[clr_cnt[AWIDTH-1:0]] <= '0;
      end else begin
         if (we_b) mem[addr_b] <= new_b;
         if (we_a) mem[addr_a] <= wr_a;
      end
   end

   // First read stage. Reads see the array before this cycle's writes,
   // except a same-port WRITE_FIRST read, which returns its own merged word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_a  <= '0;
         rd_b  <= '0;
         rv1_a <= 1'b0;
         rv1_b <= 1'b0;
      end else begin
         rv1_a <= re_a;
         rv1_b <= re_b;
         if (re_a) rd_a <= (WRITE_FIRST && we_a) ? new_a : old_a;
         if (re_b) rd_b <= (WRITE_FIRST && we_b) ? new_b : old_b;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DWIDTH-1:0] rq2_a, rq2_b;
      logic              rv2_a, rv2_b;

      // Second stage only loads on a valid first stage so rq holds between reads.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rq2_a <= '0;
            rq2_b <= '0;
            rv2_a <= 1'b0;
            rv2_b <= 1'b0;
         end else begin
            rv2_a <= rv1_a;
            rv2_b <= rv1_b;
            if (rv1_a) rq2_a <= rd_a;
            if (rv1_b) rq2_b <= rd_b;
         end
      end

      assign rq_a     = rq2_a;
      assign rq_b     = rq2_b;
      assign rvalid_a = rv2_a;
      assign rvalid_b = rv2_b;
   end else begin : g_no_out_reg
      assign rq_a     = rd_a;
      assign rq_b     = rd_b;
      assign rvalid_a = rv1_a;
      assign rvalid_b = rv1_b;
   end

endmodule

// File: tb/tb_bram_tdp_be.sv
// tb_bram_tdp_be: directed bench for bram_tdp_be.
//
// Four instances share one stimulus stream (AWIDTH=4, DWIDTH=36, BWIDTH=9):
//   u0  READ_FIRST,  no output register, clear on reset
//   u1  WRITE_FIRST, output register,    clear on reset
//   u2  NO_CHANGE,   no output register, clear on reset
//   u3  READ_FIRST,  no output register, no clear (only init_done is checked)
// u1 answers one cycle after u0/u2, so it is checked after the following idle
// cycle or one iteration later in back-to-back read loops.
module tb_bram_tdp_be;

   localparam int AW = 4;
   localparam int DW = 36;
   localparam int NB = 4;

   logic          clk;
   logic          rst;
   logic          rce_a, wce_a, rce_b, wce_b;
   logic [AW-1:0] ra_a, wa_a, ra_b, wa_b;
   logic [DW-1:0] wd_a, wd_b;
   logic [NB-1:0] wbe_a, wbe_b;

   logic [DW-1:0] rq_a [4];
   logic [DW-1:0] rq_b [4];
   logic          rvalid_a [4];
   logic          rvalid_b [4];
   logic          init_done [4];

   int checks;
   int errors;
   int n;

   localparam int RDW_P [4] = '{0, 1, 2, 0};
   localparam int OUT_P [4] = '{0, 1, 0, 0};
   localparam int CLR_P [4] = '{1, 1, 1, 0};

   for (genvar k = 0; k < 4; k++) begin : g_dut
      bram_tdp_be #(
         .AWIDTH(AW), .DWIDTH(DW), .BWIDTH(9),
         .RDW_MODE(RDW_P[k]), .OUT_REG(OUT_P[k]), .CLEAR_ON_RESET(CLR_P[k])
      ) u_dut (
         .clk(clk), .rst(rst),
         .rce_a(rce_a), .ra_a(ra_a), .wce_a(wce_a), .wa_a(wa_a),
         .wd_a(wd_a), .wbe_a(wbe_a), .rq_a(rq_a[k]), .rvalid_a(rvalid_a[k]),
         .rce_b(rce_b), .ra_b(ra_b), .wce_b(wce_b), .wa_b(wa_b),
         .wd_b(wd_b), .wbe_b(wbe_b), .rq_b(rq_b[k]), .rvalid_b(rvalid_b[k]),
         .init_done(init_done[k])
      );
   end

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests on both ports, then step past the next edge.
   task automatic applyStimulus(
      input logic a_rce, input logic [AW-1:0] a_ra, input logic a_wce,
      input logic [AW-1:0] a_wa, input logic [DW-1:0] a_wd, input logic [NB-1:0] a_wbe,
      input logic b_rce, input logic [AW-1:0] b_ra, input logic b_wce,
      input logic [AW-1:0] b_wa, input logic [DW-1:0] b_wd, input logic [NB-1:0] b_wbe);
      rce_a = a_rce; ra_a = a_ra; wce_a = a_wce; wa_a = a_wa; wd_a = a_wd; wbe_a = a_wbe;
      rce_b = b_rce; ra_b = b_ra; wce_b = b_wce; wa_b = b_wa; wd_b = b_wd; wbe_b = b_wbe;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic checkReadA(input int k, input string tag, input logic [DW-1:0] exp);
      checkOutput($sformatf("%s u%0d rq_a", tag, k), rq_a[k], exp);
      checkOutput($sformatf("%s u%0d rvalid_a", tag, k), 36'(rvalid_a[k]), 36'd1);
   endtask

   task automatic checkReadB(input int k, input string tag, input logic [DW-1:0] exp);
      checkOutput($sformatf("%s u%0d rq_b", tag, k), rq_b[k], exp);
      checkOutput($sformatf("%s u%0d rvalid_b", tag, k), 36'(rvalid_b[k]), 36'd1);
   endtask

   // Read all addresses on both ports back to back and expect zero.
   task automatic readAllZero(input string tag);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 4'(i), 0, 0, 0, 0, 1, 4'(i), 0, 0, 0, 0);
         checkReadA(0, tag, '0); checkReadB(0, tag, '0);
         checkReadA(2, tag, '0); checkReadB(2, tag, '0);
         if (i > 0) begin
            checkReadA(1, tag, '0); checkReadB(1, tag, '0);
         end
      end
      idle();
      checkReadA(1, tag, '0); checkReadB(1, tag, '0);
   endtask

   // Wait for init_done on u0 with a cycle bound; returns the edge count.
   task automatic countToReady(input logic watch_b, output int cnt);
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
         if (cnt == 1) begin
            checkOutput("no-clear init_done first edge", 36'(init_done[3]), 36'd1);
            checkOutput("clear init_done first edge", 36'(init_done[0]), 36'd0);
         end
         if (watch_b)
            checkOutput("rvalid_b during clear", 36'(rvalid_b[0]), 36'd0);
      end while (!init_done[0] && cnt < 100);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      rce_a = 0; ra_a = 0; wce_a = 0; wa_a = 0; wd_a = 0; wbe_a = 0;
      rce_b = 0; ra_b = 0; wce_b = 0; wa_b = 0; wd_b = 0; wbe_b = 0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset state of every instance.
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("reset u%0d rq_a", k), rq_a[k], '0);
         checkOutput($sformatf("reset u%0d rq_b", k), rq_b[k], '0);
         checkOutput($sformatf("reset u%0d rvalid_a", k), 36'(rvalid_a[k]), 36'd0);
         checkOutput($sformatf("reset u%0d init_done", k), 36'(init_done[k]), 36'd0);
      end

      // Clear sweep: 1 cycle to CLEAR plus 16 clear cycles.
      rst = 1'b0;
      countToReady(1'b0, n);
      checkOutput("clear latency", 36'(n), 36'd17);
      checkOutput("u1 init_done", 36'(init_done[1]), 36'd1);
      checkOutput("u2 init_done", 36'(init_done[2]), 36'd1);
      readAllZero("clear");

      // Byte enables: lanes of 0x123456789 are {24,0D1,0B3,189}; writing
      // 0x1FF into lanes 0 and 2 gives {24,1FF,0B3,1FF} = 0x127FD67FF.
      applyStimulus(0, 0, 1, 5, 36'h123456789, 4'hF, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 36'hFFFFFFFFF, 4'h5);
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkReadA(0, "byte-en", 36'h127FD67FF);
      checkReadA(2, "byte-en", 36'h127FD67FF);
      idle();
      checkReadA(1, "byte-en", 36'h127FD67FF);
      checkOutput("hold u0 rq_a", rq_a[0], 36'h127FD67FF);
      checkOutput("hold u0 rvalid_a", 36'(rvalid_a[0]), 36'd0);

      // Same-port read-during-write on address 3 (old 0xA, new 0xB).
      applyStimulus(0, 0, 1, 3, 36'hA, 4'hF, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 3, 1, 3, 36'hB, 4'hF, 0, 0, 0, 0, 0, 0);
      checkReadA(0, "rdw read-first", 36'hA);
      checkOutput("rdw no-change u2 rq_a", rq_a[2], 36'h127FD67FF);
      checkOutput("rdw no-change u2 rvalid_a", 36'(rvalid_a[2]), 36'd0);
      idle();
      checkReadA(1, "rdw write-first", 36'hB);
      checkOutput("rdw no-change u2 rvalid_a late", 36'(rvalid_a[2]), 36'd0);
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkReadA(0, "rdw after", 36'hB);
      checkReadA(2, "rdw after", 36'hB);
      idle();
      checkReadA(1, "rdw after", 36'hB);

      // Write-write collision on address 7.
      applyStimulus(0, 0, 1, 7, 36'h111111111, 4'h3, 0, 0, 1, 7, 36'h222222222, 4'hE);
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkReadA(0, "collision", 36'h222211111);
      checkReadA(2, "collision", 36'h222211111);
      idle();
      checkReadA(1, "collision", 36'h222211111);

      // Cross-port read of address 9 while A writes it; rq_b starts non-zero.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      checkReadB(0, "preload", 36'h127FD67FF);
      idle();
      checkReadB(1, "preload", 36'h127FD67FF);
      applyStimulus(0, 0, 1, 9, 36'h55, 4'hF, 1, 9, 0, 0, 0, 0);
      checkReadB(0, "cross-port", '0);
      checkReadB(2, "cross-port", '0);
      checkOutput("cross-port u1 rvalid_b early", 36'(rvalid_b[1]), 36'd0);
      checkOutput("cross-port u1 rq_b early", rq_b[1], 36'h127FD67FF);
      idle();
      checkReadB(1, "cross-port", '0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
      checkReadB(0, "cross-port after", 36'h55);
      idle();
      checkReadB(1, "cross-port after", 36'h55);

      // Reset mid-clear: outputs drop at once, the sweep restarts, and
      // writes issued before init_done are dropped.
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkReadA(0, "pre-reset", 36'hB);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("async reset u%0d rq_a", k), rq_a[k], '0);
         checkOutput($sformatf("async reset u%0d rvalid_a", k), 36'(rvalid_a[k]), 36'd0);
         checkOutput($sformatf("async reset u%0d init_done", k), 36'(init_done[k]), 36'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("mid-clear reset init_done", 36'(init_done[0]), 36'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      rce_a = 0; wce_a = 1; wa_a = 0; wd_a = 36'hABC; wbe_a = 4'hF;
      rce_b = 1; ra_b = 1; wce_b = 1; wd_b = 36'hDEF; wbe_b = 4'hF;
      countToReady(1'b1, n);
      checkOutput("restart clear latency", 36'(n), 36'd17);
      idle();
      readAllZero("after restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
